// File: rtl/apu_pulse_gen2.sv
// APU square channel: timer, duty sequencer, envelope,
// sweep unit and length counter with its load table.
module apu_pulse_gen2 #(
  parameter int TIMER_W       = 11,
  parameter bit NEG_ONES_COMP = 1'b1,
  parameter int MUTE_MIN      = 8
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       en_in,
  input  logic       apu_clk_in,
  input  logic       lc_pulse_in,
  input  logic       eg_pulse_in,
  input  logic [1:0] a_in,
  input  logic [7:0] d_in,
  input  logic       wr_in,
  output logic [3:0] pulse_out,
  output logic       active_out
);

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,
    8'd40,  8'd4,   8'd80,  8'd6,
    8'd160, 8'd8,   8'd60,  8'd10,
    8'd14,  8'd12,  8'd26,  8'd14,
    8'd12,  8'd16,  8'd24,  8'd18,
    8'd48,  8'd20,  8'd96,  8'd22,
    8'd192, 8'd24,  8'd72,  8'd26,
    8'd16,  8'd28,  8'd32,  8'd30
  };

  logic [1:0]         r_duty;
  logic               r_halt;
  logic               r_const;
  logic [3:0]         r_vol;
  logic               r_sw_en;
  logic [2:0]         r_sw_p;
  logic               r_sw_neg;
  logic [2:0]         r_sw_s;
  logic               r_sw_reload;
  logic [2:0]         r_sw_div;
  logic [TIMER_W-1:0] r_period;
  logic [TIMER_W-1:0] r_cnt;
  logic [2:0]         r_step;
  logic               r_env_start;
  logic [3:0]         r_decay;
  logic [3:0]         r_div;
  logic [7:0]         r_len;

  logic               w_wr0;
  logic               w_wr1;
  logic               w_wr2;
  logic               w_wr3;
  logic [TIMER_W:0]   w_delta;
  logic [TIMER_W:0]   w_sum;
  logic [TIMER_W:0]   w_diff;
  logic [TIMER_W:0]   w_target;
  logic               w_mute;
  logic               w_sweep;
  logic [TIMER_W-1:0] w_per_next;
  logic [7:0]         w_pat;
  logic [3:0]         w_vol;

  assign w_wr0 = wr_in && (a_in == 2'd0);
  assign w_wr1 = wr_in && (a_in == 2'd1);
  assign w_wr2 = wr_in && (a_in == 2'd2);
  assign w_wr3 = wr_in && (a_in == 2'd3);

  // Negative target floors at zero; the carry bit flags underflow.
  assign w_delta  = {1'b0, r_period} >> r_sw_s;
  assign w_sum    = {1'b0, r_period} + w_delta;
  assign w_diff   = {1'b0, r_period} - w_delta
                  - {{TIMER_W{1'b0}}, NEG_ONES_COMP};
  assign w_target = r_sw_neg
                  ? (w_diff[TIMER_W] ? '0 : w_diff)
                  : w_sum;

  assign w_mute = (r_period < TIMER_W'(MUTE_MIN))
               || (!r_sw_neg && w_target[TIMER_W]);

  assign w_sweep = lc_pulse_in && (r_sw_div == 3'd0)
                && r_sw_en && (r_sw_s != 3'd0) && !w_mute;

  always_comb begin
    w_per_next = r_period;
    if (w_sweep)
      w_per_next = w_target[TIMER_W-1:0];
    for (int i = 0; i < TIMER_W; i++) begin
      if (w_wr2 && i < 8)
        w_per_next[i] = d_in[3'(i % 8)];
      else if (w_wr3 && i >= 8 && i < 16)
        w_per_next[i] = d_in[3'(i % 8)];
    end
  end

  always_comb begin
    w_pat = 8'h00;
    unique case (r_duty)
      2'd0: w_pat = 8'b0000_0010;
      2'd1: w_pat = 8'b0000_0110;
      2'd2: w_pat = 8'b0001_1110;
      2'd3: w_pat = 8'b1111_1001;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_duty  <= '0;
      r_halt  <= 1'b0;
      r_const <= 1'b0;
      r_vol   <= '0;
    end else if (w_wr0) begin
      r_duty  <= d_in[7:6];
      r_halt  <= d_in[5];
      r_const <= d_in[4];
      r_vol   <= d_in[3:0];
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_cnt  <= '0;
      r_step <= '0;
    end else begin
      if (apu_clk_in) begin
        if (r_cnt == '0) begin
          r_cnt  <= r_period;
          r_step <= r_step + 3'd1;
        end else begin
          r_cnt <= r_cnt - TIMER_W'(1);
        end
      end
      if (w_wr3)
        r_step <= '0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_env_start <= 1'b0;
      r_decay     <= '0;
      r_div       <= '0;
    end else begin
      if (eg_pulse_in) begin
        if (r_env_start) begin
          r_env_start <= 1'b0;
          r_decay     <= 4'hF;
          r_div       <= r_vol;
        end else if (r_div == 4'd0) begin
          r_div <= r_vol;
          if (r_decay != 4'd0)
            r_decay <= r_decay - 4'd1;
          else if (r_halt)
            r_decay <= 4'hF;
        end else begin
          r_div <= r_div - 4'd1;
        end
      end
      if (w_wr3)
        r_env_start <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      r_len <= '0;
    else if (!en_in)
      r_len <= '0;
    else if (w_wr3)
      r_len <= LEN_TABLE[d_in[7:3]];
    else if (lc_pulse_in && !r_halt && r_len != 8'd0)
      r_len <= r_len - 8'd1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_period    <= '0;
      r_sw_en     <= 1'b0;
      r_sw_p      <= '0;
      r_sw_neg    <= 1'b0;
      r_sw_s      <= '0;
      r_sw_reload <= 1'b0;
      r_sw_div    <= '0;
    end else begin
      r_period <= w_per_next;
      if (lc_pulse_in) begin
        if (r_sw_div == 3'd0 || r_sw_reload) begin
          r_sw_div    <= r_sw_p;
          r_sw_reload <= 1'b0;
        end else begin
          r_sw_div <= r_sw_div - 3'd1;
        end
      end
      if (w_wr1) begin
        r_sw_en     <= d_in[7];
        r_sw_p      <= d_in[6:4];
        r_sw_neg    <= d_in[3];
        r_sw_s      <= d_in[2:0];
        r_sw_reload <= 1'b1;
      end
    end
  end

  assign w_vol      = r_const ? r_vol : r_decay;
  assign active_out = (r_len != 8'd0);
  assign pulse_out  = (active_out && !w_mute && w_pat[r_step])
                    ? w_vol : 4'd0;

endmodule
